tetris_input_ctrl: RTL and testbench

- Conditions the eight raw joystick/button pins (JB) before the CPU sees them.
- Stages: synchronise, debounce, detect presses, auto-repeat for movement keys, priority arbitration, and a small key-event FIFO.
- Replaces the level-sampled priority mux feeding CPU read register 27. The CPU pops exactly one key code per read, so each physical press is seen once.
- Also drives debounced levels to the LED indicators.

---
 rtl/tetris_input_pkg.sv | 48 ++++
 rtl/tetris_key_debounce.sv | 47 ++++
 rtl/tetris_input_ctrl.sv | 144 ++++++++++++++
 tb/tb_tetris_input_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_input_pkg.sv
// Shared key definitions for the joystick/button input conditioner.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package tetris_input_pkg;

    localparam int CODE_W = 4;

    // Bit positions within btn_raw / btn_level.
    localparam logic [2:0] BTN_UP    = 3'd0;
    localparam logic [2:0] BTN_RIGHT = 3'd1;
    localparam logic [2:0] BTN_DOWN  = 3'd2;
    localparam logic [2:0] BTN_LEFT  = 3'd3;
    localparam logic [2:0] BTN_SL    = 3'd4;
    localparam logic [2:0] BTN_SR    = 3'd5;
    localparam logic [2:0] BTN_HOLD  = 3'd6;
    localparam logic [2:0] BTN_RESET = 3'd7;

    // Codes the CPU sees when it reads the key register.
    localparam logic [CODE_W-1:0] KEY_UP    = 4'd1;
    localparam logic [CODE_W-1:0] KEY_RIGHT = 4'd2;
    localparam logic [CODE_W-1:0] KEY_DOWN  = 4'd3;
    localparam logic [CODE_W-1:0] KEY_LEFT  = 4'd4;
    localparam logic [CODE_W-1:0] KEY_SL    = 4'd7;
    localparam logic [CODE_W-1:0] KEY_SR    = 4'd8;
    localparam logic [CODE_W-1:0] KEY_HOLD  = 4'd9;
    localparam logic [CODE_W-1:0] KEY_RESET = 4'd10;

    // Movement keys that auto-repeat while held: Right, Down, Left.
    localparam logic [7:0] REPEATABLE = 8'b0000_1110;

    // Arbitration order; element [0] is the highest priority.
    localparam logic [7:0][2:0] PRIO_ORDER = {BTN_UP, BTN_RIGHT, BTN_DOWN, BTN_LEFT,
                                              BTN_SL, BTN_SR, BTN_HOLD, BTN_RESET};

    function automatic logic [CODE_W-1:0] code_of(input logic [2:0] idx);
        case (idx)
            BTN_UP:    code_of = KEY_UP;
            BTN_RIGHT: code_of = KEY_RIGHT;
            BTN_DOWN:  code_of = KEY_DOWN;
            BTN_LEFT:  code_of = KEY_LEFT;
            BTN_SL:    code_of = KEY_SL;
            BTN_SR:    code_of = KEY_SR;
            BTN_HOLD:  code_of = KEY_HOLD;
            default:   code_of = KEY_RESET;
        endcase
    endfunction

endpackage

// File: rtl/tetris_key_debounce.sv
// Two-flop synchroniser plus debounce counter for one button pin.
// Latency: raw change to level change is 2 + DEBOUNCE_CYCLES cycles; rise pulses with the new level.
// Backpressure: none, free-running.
// Ports: clock, reset (sync, active-low), raw (async pin) -> level (debounced), rise (1-cycle press pulse).
module tetris_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Any cycle where the synced pin agrees with the level restarts the count,
            // so only an unbroken run of disagreement flips the level.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync2;
                rise  <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Conditions 8 button pins into debounced levels and a queue of one-shot key codes for the CPU.
// Latency: pin to key_valid is 2 + DEBOUNCE_CYCLES + 2 cycles when the queue has room.
// Backpressure: a full queue holds events in per-key pending flags; overflow flags a long stall.
// Ports: clock, reset (sync, active-low), btn_raw[7:0], rd_en (pop) -> key_code[31:0], key_valid,
//        btn_level[7:0], overflow (sticky).
module tetris_input_ctrl
    import tetris_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 15000000,
    parameter int REPEAT_PERIOD   = 5000000,   // must not exceed REPEAT_DELAY
    parameter int FIFO_DEPTH      = 4          // power of two, >= 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  btn_raw,
    input  logic        rd_en,
    output logic [31:0] key_code,
    output logic        key_valid,
    output logic [7:0]  btn_level,
    output logic        overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam int OW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [7:0] rise;
    logic [7:0] rep_fire;

    for (genvar i = 0; i < 8; i++) begin : g_btn
        tetris_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clock (clock),
            .reset (reset),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .rise  (rise[i])
        );

        if (REPEATABLE[i]) begin : g_rep
            // hold_cnt equals the number of cycles since the rise while the key is held.
            // After the first repeat it is wound back by REPEAT_PERIOD so the same
            // compare fires every period without a second comparator.
            logic [HW-1:0] hold_cnt;

            always_ff @(posedge clock) begin
                if (!reset || !btn_level[i]) begin
                    hold_cnt <= '0;
                end else if (rise[i]) begin
                    hold_cnt <= HW'(1);
                end else if (hold_cnt == HW'(REPEAT_DELAY)) begin
                    hold_cnt <= HW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
                end else begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end

            assign rep_fire[i] = btn_level[i] && (hold_cnt == HW'(REPEAT_DELAY));
        end else begin : g_norep
            assign rep_fire[i] = 1'b0;
        end
    end

    logic [7:0]        pending;
    logic [7:0]        grant;
    logic [CODE_W-1:0] grant_code;
    logic              found;

    always_comb begin
        grant      = '0;
        grant_code = '0;
        found      = 1'b0;
        for (int p = 0; p < 8; p++) begin
            if (!found && pending[PRIO_ORDER[3'(p)]]) begin
                found                    = 1'b1;
                grant[PRIO_ORDER[3'(p)]] = 1'b1;
                grant_code               = code_of(PRIO_ORDER[3'(p)]);
            end
        end
    end

    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [OW-1:0]     ovf_cnt;
    logic              full;
    logic              do_pop;
    logic              do_push;
    logic              blocked;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = rd_en && (count != '0);
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign do_push = (pending != 8'h00) && (!full || rd_en);
    assign blocked = full && (pending != 8'h00) && !rd_en;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= grant_code;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pending  <= '0;
            ovf_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
            // New events OR into the flags, so a repeat landing on a still-pending
            // key merges instead of queueing a duplicate.
            pending <= (pending & ~(do_push ? grant : 8'h00)) | rise | rep_fire;

            if (blocked) begin
                if (ovf_cnt == OW'(DEBOUNCE_CYCLES - 1)) begin
                    overflow <= 1'b1;
                end else begin
                    ovf_cnt <= ovf_cnt + OW'(1);
                end
            end else begin
                ovf_cnt <= '0;
            end
        end
    end

    assign key_valid = (count != '0);
    assign key_code  = key_valid ? {{(32 - CODE_W){1'b0}}, mem[rd_ptr]} : 32'd0;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
module tb_tetris_input_ctrl;

    logic        clock;
    logic        reset;
    logic [7:0]  btn_raw;
    logic        rd_en;
    logic [31:0] key_code;
    logic        key_valid;
    logic [7:0]  btn_level;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int expq[$];
    int mon_exp;

    tetris_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .FIFO_DEPTH      (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .rd_en     (rd_en),
        .key_code  (key_code),
        .key_valid (key_valid),
        .btn_level (btn_level),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Key code the CPU should see for each button bit.
    function automatic int code_for(input int b);
        case (b)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 4;
            4: return 7;
            5: return 8;
            6: return 9;
            default: return 10;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(key_valid), (expq.size() != 0) ? 32'd1 : 32'd0);
        check({tag, "_head"}, key_code, (expq.size() != 0) ? 32'(expq[0]) : 32'd0);
    endtask

    // Scoreboard monitor: every CPU read is compared against the oldest expected code.
    always @(negedge clock) begin
        if (reset && rd_en) begin
            if (expq.size() > 0) begin
                mon_exp = expq.pop_front();
                check("pop_valid", 32'(key_valid), 32'd1);
                check("pop_code", key_code, 32'(mon_exp));
            end else begin
                check("pop_empty_valid", 32'(key_valid), 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        btn_raw = 8'h00;
        rd_en   = 1'b0;

        // Reset state
        tick(3);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_code", key_code, 32'd0);
        check("rst_level", 32'(btn_level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b1;

        // Glitch shorter than the debounce window is ignored
        btn_raw = 8'h01;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) btn_raw = 8'h00;
            tick(1);
            check("glitch_valid", 32'(key_valid), 32'd0);
            check("glitch_level", 32'(btn_level), 32'd0);
        end

        // Clean press of Up: level after 6 cycles, code two cycles later
        btn_raw = 8'h01;
        tick(5);
        check("up_level_early", 32'(btn_level), 32'd0);
        tick(1);
        check("up_level", 32'(btn_level), 32'd1);
        tick(1);
        check("up_valid_early", 32'(key_valid), 32'd0);
        tick(1);
        check("up_valid", 32'(key_valid), 32'd1);
        check("up_code", key_code, 32'd1);

        // Single pop, then a pop while empty
        expq.push_back(1);
        pop_one();
        check("pop1_code_after", key_code, 32'd0);
        check("pop1_valid_after", 32'(key_valid), 32'd0);
        pop_one();
        check("empty_pop_valid", 32'(key_valid), 32'd0);
        check("empty_pop_level", 32'(btn_level), 32'd1);
        btn_raw = 8'h00;
        tick(10);

        // Simultaneous Up, Left, Hold
        btn_raw = 8'h49;
        tick(8);
        check("simul_head", key_code, 32'd9);
        expq.push_back(9);
        expq.push_back(4);
        expq.push_back(1);
        tick(2);
        repeat (3) pop_one();
        check_idle("simul_drained");
        btn_raw = 8'h00;
        tick(10);

        // Auto-repeat Left with SL held alongside; queue fills and back-pressures
        btn_raw = 8'h18;
        tick(6);
        check("rep_level", 32'(btn_level), 32'h18);
        tick(38);
        check("rep_ovf_early", 32'(overflow), 32'd0);
        check("rep_valid", 32'(key_valid), 32'd1);
        check("rep_head", key_code, 32'd7);
        tick(7);
        check("rep_ovf", 32'(overflow), 32'd1);
        tick(5);
        btn_raw = 8'h00;
        tick(10);
        // Queue holds 7,4,4,4; the merged pending Left enters on the first pop.
        expq.push_back(7);
        repeat (4) expq.push_back(4);
        repeat (5) pop_one();
        check_idle("rep_drained");

        // Reset with three queued and Right in flight
        btn_raw = 8'h31;
        tick(10);
        check("prerst_head", key_code, 32'd8);
        btn_raw = 8'h02;
        tick(3);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        expq.delete();
        check("midrst_valid", 32'(key_valid), 32'd0);
        check("midrst_level", 32'(btn_level), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        tick(5);
        check("right_level_early", 32'(btn_level), 32'd0);
        tick(1);
        check("right_level", 32'(btn_level), 32'd2);
        tick(1);
        check("right_valid_early", 32'(key_valid), 32'd0);
        tick(1);
        check("right_code", key_code, 32'd2);
        expq.push_back(2);
        btn_raw = 8'h00;
        pop_one();
        tick(10);
        check_idle("right_drained");

        // Full queue back-pressure on Down
        btn_raw = 8'h71;
        tick(6);
        btn_raw = 8'h00;
        tick(12);
        expq.push_back(9);
        expq.push_back(8);
        expq.push_back(7);
        expq.push_back(1);
        check_idle("fill");
        check("fill_ovf", 32'(overflow), 32'd0);
        btn_raw = 8'h04;
        tick(6);
        btn_raw = 8'h00;
        tick(12);
        check("bp_ovf", 32'(overflow), 32'd1);
        check("bp_head", key_code, 32'd9);
        expq.push_back(3);
        repeat (5) pop_one();
        check_idle("bp_drained");

        // Randomized: clean presses of 1..4 keys, optional glitch, random reads
        for (int it = 0; it < 40; it++) begin
            logic [7:0] mask;
            int k;
            int r;
            k    = int'($urandom_range(1, 4));
            mask = 8'h00;
            while ($countones(mask) < k) mask = mask | (8'h01 << $urandom_range(0, 7));
            while (expq.size() + k > 4) pop_one();
            if ($urandom_range(0, 1) == 1) begin
                btn_raw = 8'h01 << $urandom_range(0, 7);
                tick(int'($urandom_range(1, 3)));
                btn_raw = 8'h00;
                tick(2);
            end
            btn_raw = mask;
            for (int b = 7; b >= 0; b--) begin
                if (((mask >> b) & 8'h01) != 8'h00) expq.push_back(code_for(b));
            end
            tick(int'($urandom_range(5, 12)));
            btn_raw = 8'h00;
            tick(14);
            check_idle("rnd");
            r = int'($urandom_range(0, expq.size()));
            repeat (r) pop_one();
        end

        while (expq.size() > 0) pop_one();
        tick(2);
        check_idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
